// File: rtl/fft_frame_buffer_if.sv
// Output sample stream of the FFT frame buffer: valid/ready handshake with
// complex data, bin index and frame-last sidebands.
interface fft_frame_buffer_if #(
    parameter int TOTAL_STEP = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_real;
    logic [DATA_WIDTH-1:0] m_imag;
    logic [TOTAL_STEP-1:0] m_index;
    logic                  m_last;

    modport master (
        output m_valid, m_real, m_imag, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_real, m_imag, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer behind the streaming FFT core: captures N-point frames,
// optionally undoes bit-reversed ordering, and replays them on a valid/ready stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for rd_bank to fill; reads address 0 when it does
// S_PRIME  | first word of the frame lands in the output registers
// S_STREAM | m_valid high; each handshake advances, next word prefetched
module fft_frame_buffer #(
    parameter int TOTAL_STEP  = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int BIT_REVERSE = 0,
    parameter int OVF_WIDTH   = 8
) (
    input  logic                  iclk,
    input  logic                  rstn,
    input  logic                  ien,
    input  logic [DATA_WIDTH-1:0] iReal,
    input  logic [DATA_WIDTH-1:0] iImag,
    fft_frame_buffer_if.master    m_if,
    output logic                  ovf_pulse,
    output logic [OVF_WIDTH-1:0]  ovf_cnt
);

    localparam int N  = 1 << TOTAL_STEP;
    localparam int AW = TOTAL_STEP + 1;
    localparam int WW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} rd_state_t;

    logic [WW-1:0]         mem [0:2*N-1];
    logic [WW-1:0]         rd_q;
    logic [AW-1:0]         rd_addr;

    logic [TOTAL_STEP-1:0] wr_cnt;
    logic                  wr_bank;
    logic                  drop_q;
    logic [1:0]            full;
    logic [1:0]            full_n;
    logic                  frame_start;
    logic                  frame_end;
    logic                  bank_free;
    logic                  drop_cur;
    logic                  wr_en;
    logic                  wr_set;

    rd_state_t             state, state_n;
    logic                  rd_bank, rd_bank_n;
    logic                  rd_release;
    logic                  hs;
    logic                  valid_n;
    logic [TOTAL_STEP-1:0] idx_n;
    logic [DATA_WIDTH-1:0] real_n, imag_n;
    logic [TOTAL_STEP:0]   tgt;

    function automatic logic [TOTAL_STEP-1:0] addr_map(input logic [TOTAL_STEP-1:0] i);
        logic [TOTAL_STEP-1:0] r;
        r = i;
        if (BIT_REVERSE != 0) begin
            for (int b = 0; b < TOTAL_STEP; b++) r[b] = i[TOTAL_STEP-1-b];
        end
        return r;
    endfunction

    // A bank the reader releases on this very edge is free for the writer to claim.
    assign frame_start = ien && (wr_cnt == '0);
    assign frame_end   = ien && (wr_cnt == TOTAL_STEP'(N-1));
    assign bank_free   = !full[wr_bank] || (rd_release && (rd_bank == wr_bank));
    assign drop_cur    = frame_start ? !bank_free : drop_q;
    assign wr_en       = ien && !drop_cur;
    assign wr_set      = frame_end && !drop_cur;

    always_comb begin
        full_n = full;
        if (rd_release) full_n[rd_bank] = 1'b0;
        if (wr_set)     full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            drop_q    <= 1'b0;
            full      <= 2'b00;
            ovf_pulse <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            full      <= full_n;
            ovf_pulse <= 1'b0;
            if (ien) wr_cnt <= wr_cnt + TOTAL_STEP'(1);
            if (frame_start) drop_q <= !bank_free;
            if (frame_end) begin
                if (drop_cur) begin
                    ovf_pulse <= 1'b1;
                    if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_WIDTH'(1);
                end else begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (wr_en) mem[{wr_bank, wr_cnt}] <= {iReal, iImag};
        rd_q <= mem[rd_addr];
    end

    assign hs = m_if.m_valid && m_if.m_ready;

    always_comb begin
        state_n    = state;
        rd_bank_n  = rd_bank;
        valid_n    = m_if.m_valid;
        idx_n      = m_if.m_index;
        real_n     = m_if.m_real;
        imag_n     = m_if.m_imag;
        rd_release = 1'b0;
        tgt        = '0;
        rd_addr    = {rd_bank, addr_map('0)};
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) state_n = S_PRIME;
            end
            S_PRIME: begin
                valid_n          = 1'b1;
                idx_n            = '0;
                {real_n, imag_n} = rd_q;
                rd_addr          = {rd_bank, addr_map(TOTAL_STEP'(1))};
                state_n          = S_STREAM;
            end
            S_STREAM: begin
                // Keep rd_q one word ahead; past N-1 the prefetch crosses into the other bank.
                tgt     = {1'b0, m_if.m_index} + (hs ? AW'(2) : AW'(1));
                rd_addr = {rd_bank ^ tgt[TOTAL_STEP], addr_map(tgt[TOTAL_STEP-1:0])};
                if (hs) begin
                    {real_n, imag_n} = rd_q;
                    idx_n            = m_if.m_index + TOTAL_STEP'(1);
                    if (m_if.m_index == TOTAL_STEP'(N-1)) begin
                        rd_release = 1'b1;
                        rd_bank_n  = ~rd_bank;
                        if (!full[~rd_bank]) begin
                            valid_n = 1'b0;
                            idx_n   = '0;
                            state_n = S_IDLE;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            rd_bank        <= 1'b0;
            m_if.m_valid   <= 1'b0;
            m_if.m_index   <= '0;
            m_if.m_real    <= '0;
            m_if.m_imag    <= '0;
        end else begin
            state          <= state_n;
            rd_bank        <= rd_bank_n;
            m_if.m_valid   <= valid_n;
            m_if.m_index   <= idx_n;
            m_if.m_real    <= real_n;
            m_if.m_imag    <= imag_n;
        end
    end

    assign m_if.m_last = m_if.m_valid && (m_if.m_index == TOTAL_STEP'(N-1));

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: natural-order and bit-reversed instances share
// stimulus and are checked every cycle against a frame-queue model.
module tb_fft_frame_buffer;

    logic        iclk = 1'b0;
    logic        rstn = 1'b0;
    logic        ien = 1'b0;
    logic [15:0] iReal = '0;
    logic [15:0] iImag = '0;
    logic        ready = 1'b0;
    logic        ovf_pulse0, ovf_pulse1;
    logic [7:0]  ovf_cnt0, ovf_cnt1;

    fft_frame_buffer_if #(.TOTAL_STEP(6), .DATA_WIDTH(16)) if0 ();
    fft_frame_buffer_if #(.TOTAL_STEP(6), .DATA_WIDTH(16)) if1 ();
    assign if0.m_ready = ready;
    assign if1.m_ready = ready;

    fft_frame_buffer #(.TOTAL_STEP(6), .DATA_WIDTH(16), .BIT_REVERSE(0), .OVF_WIDTH(8)) dut0 (
        .iclk(iclk), .rstn(rstn), .ien(ien), .iReal(iReal), .iImag(iImag),
        .m_if(if0), .ovf_pulse(ovf_pulse0), .ovf_cnt(ovf_cnt0));

    fft_frame_buffer #(.TOTAL_STEP(6), .DATA_WIDTH(16), .BIT_REVERSE(1), .OVF_WIDTH(8)) dut1 (
        .iclk(iclk), .rstn(rstn), .ien(ien), .iReal(iReal), .iImag(iImag),
        .m_if(if1), .ovf_pulse(ovf_pulse1), .ovf_cnt(ovf_cnt1));

    always #5 iclk = ~iclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge iclk) cyc++;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int bitrev6(int v);
        int r = 0;
        for (int b = 0; b < 6; b++) if (v[b]) r |= (1 << (5 - b));
        return r;
    endfunction

    // Model: completed frames live in sq (64 words each), oldest first.
    logic [31:0] sq[$];
    logic [31:0] cur [64];
    int  rcnt = 0, wcnt = 0, exp_ovf = 0;
    bit  exp_valid = 0, priming = 0, wdrop = 0, exp_pulse = 0;

    logic [15:0] log_r0[$], log_r1[$];
    int          log_idx[$], log_cyc[$];
    int          npulse = 0;

    always @(negedge iclk) begin
        if (!rstn) begin
            sq.delete();
            rcnt = 0; wcnt = 0; exp_ovf = 0;
            exp_valid = 0; priming = 0; wdrop = 0; exp_pulse = 0;
            chk("rst_valid", if0.m_valid, 0);
            chk("rst_valid_br", if1.m_valid, 0);
            chk("rst_real", if0.m_real, 0);
            chk("rst_imag", if0.m_imag, 0);
            chk("rst_index", if0.m_index, 0);
            chk("rst_last", if0.m_last, 0);
            chk("rst_ovf_pulse", ovf_pulse0, 0);
            chk("rst_ovf_cnt", ovf_cnt0, 0);
        end else begin
            chk("valid", if0.m_valid, exp_valid);
            chk("valid_br", if1.m_valid, exp_valid);
            chk("last", if0.m_last, exp_valid && rcnt == 63);
            chk("last_br", if1.m_last, exp_valid && rcnt == 63);
            if (exp_valid) begin
                chk("index", if0.m_index, rcnt);
                chk("real", if0.m_real, sq[rcnt][31:16]);
                chk("imag", if0.m_imag, sq[rcnt][15:0]);
                chk("index_br", if1.m_index, rcnt);
                chk("real_br", if1.m_real, sq[bitrev6(rcnt)][31:16]);
                chk("imag_br", if1.m_imag, sq[bitrev6(rcnt)][15:0]);
            end
            chk("ovf_pulse", ovf_pulse0, exp_pulse);
            chk("ovf_pulse_br", ovf_pulse1, exp_pulse);
            chk("ovf_cnt", ovf_cnt0, exp_ovf);
            chk("ovf_cnt_br", ovf_cnt1, exp_ovf);

            if (if0.m_valid && ready) begin
                log_r0.push_back(if0.m_real);
                log_r1.push_back(if1.m_real);
                log_idx.push_back(int'(if0.m_index));
                log_cyc.push_back(cyc);
            end
            if (ovf_pulse0) npulse++;

            // Reader first, so a frame freed this edge is visible to the writer's claim.
            if (exp_valid) begin
                if (ready) begin
                    if (rcnt == 63) begin
                        for (int j = 0; j < 64; j++) void'(sq.pop_front());
                        rcnt = 0;
                        if (sq.size() < 64) exp_valid = 0;
                    end else begin
                        rcnt++;
                    end
                end
            end else if (priming) begin
                exp_valid = 1; rcnt = 0; priming = 0;
            end else if (sq.size() >= 64) begin
                priming = 1;
            end

            exp_pulse = 0;
            if (ien) begin
                if (wcnt == 0) wdrop = (sq.size() >= 128);
                cur[wcnt] = {iReal, iImag};
                if (wcnt == 63) begin
                    if (!wdrop) begin
                        for (int j = 0; j < 64; j++) sq.push_back(cur[j]);
                    end else begin
                        exp_pulse = 1;
                        if (exp_ovf < 255) exp_ovf++;
                    end
                end
                wcnt = (wcnt + 1) % 64;
            end
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ien = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic clear_log();
        log_r0.delete(); log_r1.delete(); log_idx.delete(); log_cyc.delete();
        npulse = 0;
    endtask

    int last_cyc = 0;
    task automatic send(int n, int base, bit ramp);
        for (int i = 0; i < n; i++) begin
            ien = 1'b1;
            iReal = ramp ? 16'(base + i) : 16'($urandom);
            iImag = ramp ? 16'(-(base + i)) : 16'($urandom);
            if (i == n - 1) last_cyc = cyc;
            tick();
        end
        ien = 1'b0;
    endtask

    task automatic wait_beats(int n, int bound);
        for (int t = 0; t < bound && log_r0.size() < n; t++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, first_cyc, stall_left;
        bit stalled, hit;

        // Reset with ien toggling, then a partial frame must not produce output.
        rstn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ien = ~ien; iReal = 16'($urandom);
            tick();
        end
        rstn = 1'b1;
        ien = 1'b0;
        tick();
        clear_log();
        ready = 1'b1;
        send(40, 0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("partial_no_output", log_r0.size(), 0);

        // Single ramp frame, free-flowing consumer.
        do_reset();
        clear_log();
        ready = 1'b1;
        send(64, 0, 1);
        for (int t = 0; t < 20 && !if0.m_valid; t++) tick();
        first_cyc = cyc;
        chk("latency", first_cyc - last_cyc, 3);
        wait_beats(64, 200);
        chk("single_beats", log_r0.size(), 64);
        if (log_r0.size() == 64) begin
            bad = 0;
            for (int j = 0; j < 64; j++)
                if (log_r0[j] != 16'(j) || log_idx[j] != j) bad++;
            chk("single_order", bad, 0);
            chk("br_beat1", log_r1[1], 32);
            chk("br_beat3", log_r1[3], 48);
            chk("br_beat63", log_r1[63], 63);
            chk("single_gapless", log_cyc[63] - log_cyc[0], 63);
        end

        // Back-pressure: alternating ready plus a 5-cycle stall at index 20.
        do_reset();
        clear_log();
        ready = 1'b0;
        send(64, 0, 1);
        stalled = 0;
        stall_left = 0;
        for (int t = 0; t < 400 && log_r0.size() < 64; t++) begin
            if (!stalled && if0.m_valid && if0.m_index == 6'd20) begin
                stall_left = 5;
                stalled = 1;
            end
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = (t % 2 == 0);
            end
            tick();
        end
        ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_stall_hit", stalled, 1);
        chk("bp_beats", log_r0.size(), 64);
        bad = 0;
        for (int j = 0; j < log_r0.size(); j++) if (log_r0[j] != 16'(j)) bad++;
        chk("bp_order", bad, 0);

        // Overflow: three back-to-back frames into a stalled consumer.
        do_reset();
        clear_log();
        ready = 1'b0;
        send(192, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("ovf_cnt_after", ovf_cnt0, 1);
        chk("ovf_pulses", npulse, 1);
        ready = 1'b1;
        wait_beats(128, 300);
        chk("ovf_beats", log_r0.size(), 128);
        if (log_r0.size() == 128) chk("ovf_gapless", log_cyc[127] - log_cyc[0], 127);
        for (int i = 0; i < 10; i++) tick();
        chk("ovf_no_third", log_r0.size(), 128);

        // Reset while frame 1 streams and frame 2 is half written.
        do_reset();
        clear_log();
        ready = 1'b1;
        send(64, 0, 1);
        hit = 0;
        for (int i = 0; i < 64 && !hit; i++) begin
            ien = 1'b1;
            iReal = 16'(500 + i);
            iImag = 16'(-(500 + i));
            tick();
            if (if0.m_valid && if0.m_index == 6'd30) hit = 1;
        end
        chk("mr_hit", hit, 1);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ien = ~ien;
            tick();
        end
        rstn = 1'b1;
        ien = 1'b0;
        tick();
        clear_log();
        send(64, 1000, 1);
        wait_beats(64, 200);
        chk("mr_beats", log_r0.size(), 64);
        if (log_r0.size() > 0) begin
            chk("mr_first_real", log_r0[0], 1000);
            chk("mr_first_index", log_idx[0], 0);
        end

        // Random traffic with varying consumer throughput.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            int thr;
            thr = $urandom_range(1, 8);
            for (int t = 0; t < 500; t++) begin
                ien = ($urandom % 5) != 0;
                iReal = 16'($urandom);
                iImag = 16'($urandom);
                ready = ($urandom % 8) < thr;
                tick();
            end
        end
        ien = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("rand_drained", if0.m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
